// File: rtl/psram_pkg.sv
// Shared definitions for the QSPI PSRAM device model: FSM states,
// supported opcodes and data-path widths.
package psram_pkg;

  localparam int IO_W   = 4;
  localparam int BYTE_W = 8;

  localparam logic [7:0] OP_QREAD  = 8'hEB;
  localparam logic [7:0] OP_QWRITE = 8'h38;
  localparam logic [7:0] OP_QPI_EN = 8'h35;
  localparam logic [7:0] OP_QPI_EX = 8'hF5;

  typedef enum logic [2:0] {
    ST_CMD,
    ST_ADDR,
    ST_DUMMY,
    ST_RDATA,
    ST_WDATA,
    ST_IGNORE
  } state_e;

endpackage

// File: rtl/psram_mem.sv
// Byte-wide backing store: combinational read, write on posedge sck.
// Contents are deliberately left uninitialised.
module psram_mem
  import psram_pkg::*;
#(
  parameter int MEM_BYTES = 4096,
  parameter int MAW       = $clog2(MEM_BYTES)
) (
  input  logic              sck,
  input  logic              we_i,
  input  logic [MAW-1:0]    addr_i,
  input  logic [BYTE_W-1:0] wdata_i,
  output logic [BYTE_W-1:0] rdata_o
);

  logic [BYTE_W-1:0] mem_q [MEM_BYTES];

  // store one byte when the controller completes a write nibble pair
  always_ff @(posedge sck) begin
    if (we_i) mem_q[addr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/psram_qspi_dev.sv
// QSPI/QPI PSRAM device: command, address, dummy and data phases driven
// by the host's sck. ce_n high aborts a transaction asynchronously.
module psram_qspi_dev
  import psram_pkg::*;
#(
  parameter int ADDR_W    = 24,
  parameter int MEM_BYTES = 4096,
  parameter int RD_DUMMY  = 6
) (
  input  logic            sck,
  input  logic            reset,
  input  logic            ce_n,
  input  logic [IO_W-1:0] dio_i,
  output logic [IO_W-1:0] dio_o,
  output logic [IO_W-1:0] dio_oe,
  output logic            qpi_mode,
  output logic            cmd_err
);

  localparam int NIB_A = ADDR_W / 4;
  localparam int MAXC0 = (NIB_A > 8) ? NIB_A : 8;
  localparam int MAXC  = (RD_DUMMY > MAXC0) ? RD_DUMMY : MAXC0;
  localparam int CW    = $clog2(MAXC);
  localparam int MAW   = $clog2(MEM_BYTES);

  localparam logic [CW-1:0] CMD_LAST_SPI = CW'(7);
  localparam logic [CW-1:0] CMD_LAST_QPI = CW'(1);
  localparam logic [CW-1:0] ADDR_LAST    = CW'(NIB_A - 1);
  localparam logic [CW-1:0] DUM_LAST     = CW'(RD_DUMMY - 1);

  state_e            state_q;
  logic [CW-1:0]     cnt_q;
  logic [ADDR_W-1:0] addr_q;
  logic [7:0]        op_q;
  logic              nib_q;
  logic [IO_W-1:0]   hi_q;
  logic              qpi_q;

  logic [7:0]        op_shift;
  logic              cmd_last;
  logic              mem_we;
  logic [BYTE_W-1:0] rbyte;

  // opcode including this cycle's bit(s); valid as a whole on the last CMD cycle
  assign op_shift = qpi_q ? {op_q[3:0], dio_i} : {op_q[6:0], dio_i[0]};
  assign cmd_last = (state_q == ST_CMD) &&
                    (cnt_q == (qpi_q ? CMD_LAST_QPI : CMD_LAST_SPI));
  // low nibble of a pair completes the byte
  assign mem_we   = (state_q == ST_WDATA) && nib_q;

  psram_mem #(.MEM_BYTES(MEM_BYTES), .MAW(MAW)) u_mem (
    .sck     (sck),
    .we_i    (mem_we),
    .addr_i  (addr_q[MAW-1:0]),
    .wdata_i ({hi_q, dio_i}),
    .rdata_o (rbyte)
  );

  // transaction FSM; ce_n high or reset returns it to the command phase
  always_ff @(posedge sck or posedge reset or posedge ce_n) begin
    if (reset || ce_n) begin
      state_q <= ST_CMD;
      cnt_q   <= '0;
      addr_q  <= '0;
      op_q    <= '0;
      nib_q   <= 1'b0;
      hi_q    <= '0;
      cmd_err <= 1'b0;
    end else begin
      cmd_err <= 1'b0;
      case (state_q)
        ST_CMD: begin
          op_q  <= op_shift;
          cnt_q <= cnt_q + 1'b1;
          if (cmd_last) begin
            cnt_q <= '0;
            case (op_shift)
              OP_QREAD, OP_QWRITE:  state_q <= ST_ADDR;
              OP_QPI_EN, OP_QPI_EX: state_q <= ST_IGNORE;
              default: begin
                state_q <= ST_IGNORE;
                cmd_err <= 1'b1;
              end
            endcase
          end
        end
        ST_ADDR: begin
          addr_q <= {addr_q[ADDR_W-5:0], dio_i};
          cnt_q  <= cnt_q + 1'b1;
          if (cnt_q == ADDR_LAST) begin
            cnt_q   <= '0;
            state_q <= (op_q == OP_QREAD) ? ST_DUMMY : ST_WDATA;
          end
        end
        ST_DUMMY: begin
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == DUM_LAST) begin
            cnt_q   <= '0;
            state_q <= ST_RDATA;
          end
        end
        ST_RDATA: begin
          nib_q <= ~nib_q;
          if (nib_q) addr_q <= addr_q + 1'b1;
        end
        ST_WDATA: begin
          nib_q <= ~nib_q;
          if (!nib_q) hi_q   <= dio_i;
          else        addr_q <= addr_q + 1'b1;
        end
        ST_IGNORE: ;
        default: state_q <= ST_CMD;
      endcase
    end
  end

  // QPI mode survives ce_n; only reset or the mode opcodes change it
  always_ff @(posedge sck or posedge reset) begin
    if (reset) begin
      qpi_q <= 1'b0;
    end else if (!ce_n && cmd_last) begin
      if (op_shift == OP_QPI_EN)      qpi_q <= 1'b1;
      else if (op_shift == OP_QPI_EX) qpi_q <= 1'b0;
    end
  end

  assign qpi_mode = qpi_q;
  assign dio_oe   = (state_q == ST_RDATA) ? {IO_W{1'b1}} : '0;
  assign dio_o    = (state_q == ST_RDATA) ? (nib_q ? rbyte[3:0] : rbyte[7:4]) : '0;

endmodule

// File: tb/tb_psram_qspi_dev.sv
// Directed + randomized bench for psram_qspi_dev against a byte-array model.
module tb_psram_qspi_dev;

  localparam int ADDR_W    = 24;
  localparam int MEM_BYTES = 4096;
  localparam int RD_DUMMY  = 6;

  logic       sck   = 1'b0;
  logic       reset = 1'b1;
  logic       ce_n  = 1'b1;
  logic [3:0] dio_i = 4'h0;
  logic [3:0] dio_o, dio_oe;
  logic       qpi_mode, cmd_err;

  int tests = 0;
  int fails = 0;

  logic [7:0] mdl [MEM_BYTES];
  logic [7:0] wq [$];
  bit         m_qpi = 1'b0;

  psram_qspi_dev #(.ADDR_W(ADDR_W), .MEM_BYTES(MEM_BYTES), .RD_DUMMY(RD_DUMMY)) dut (
    .sck      (sck),
    .reset    (reset),
    .ce_n     (ce_n),
    .dio_i    (dio_i),
    .dio_o    (dio_o),
    .dio_oe   (dio_oe),
    .qpi_mode (qpi_mode),
    .cmd_err  (cmd_err)
  );

  always #5 sck = ~sck;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish (observed timeout, required completion)");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // hold d across one posedge, return at the following negedge
  task automatic cyc(input logic [3:0] d);
    dio_i = d;
    @(posedge sck);
    @(negedge sck);
  endtask

  task automatic stop();
    ce_n  = 1'b1;
    dio_i = 4'h0;
    @(posedge sck);
    @(negedge sck);
  endtask

  task automatic send_cmd(input logic [7:0] op);
    if (m_qpi) begin
      cyc(op[7:4]);
      cyc(op[3:0]);
    end else begin
      for (int i = 7; i >= 0; i--) cyc({3'b000, op[i]});
    end
  endtask

  task automatic send_addr(input int a);
    logic [ADDR_W-1:0] av;
    av = a[ADDR_W-1:0];
    for (int i = ADDR_W/4 - 1; i >= 0; i--) cyc(av[i*4 +: 4]);
  endtask

  // write n_nib nibbles from wq; only complete bytes reach the model
  task automatic wr_burst(input int a, input int n_nib);
    logic [7:0] b;
    ce_n = 1'b0;
    send_cmd(8'h38);
    chk("wr_cmd_err", cmd_err, 0);
    send_addr(a);
    for (int k = 0; k < n_nib; k++) begin
      b = wq[k/2];
      cyc((k % 2 == 0) ? b[7:4] : b[3:0]);
      chk("wr_oe", dio_oe, 0);
    end
    for (int k = 0; k < n_nib/2; k++) mdl[(a + k) % MEM_BYTES] = wq[k];
    stop();
  endtask

  task automatic rd_burst(input string tag, input int a, input int nbytes);
    logic [7:0] e;
    ce_n = 1'b0;
    send_cmd(8'hEB);
    chk("rd_cmd_err", cmd_err, 0);
    send_addr(a);
    for (int i = 0; i < RD_DUMMY; i++) begin
      chk("dummy_oe", dio_oe, 0);
      cyc(4'h0);
    end
    for (int k = 0; k < 2*nbytes; k++) begin
      e = mdl[(a + k/2) % MEM_BYTES];
      chk({tag, "_oe"}, dio_oe, 4'hF);
      chk(tag, dio_o, (k % 2 == 0) ? e[7:4] : e[3:0]);
      cyc(4'h0);
    end
    stop();
  endtask

  task automatic set_mode(input bit q);
    ce_n = 1'b0;
    send_cmd(q ? 8'h35 : 8'hF5);
    chk("mode_cmd_err", cmd_err, 0);
    stop();
    m_qpi = q;
    chk("qpi_mode", qpi_mode, q);
  endtask

  initial begin
    int a, n;
    repeat (2) @(negedge sck);
    chk("rst_qpi", qpi_mode, 0);
    chk("rst_err", cmd_err, 0);
    chk("rst_oe", dio_oe, 0);
    chk("rst_do", dio_o, 0);
    reset = 1'b0;
    @(negedge sck);

    // SPI write 12 34 56 78 at 0x10, read back as nibbles 1..8
    wq = '{8'h12, 8'h34, 8'h56, 8'h78};
    wr_burst(32'h10, 8);
    rd_burst("rd_basic", 32'h10, 4);

    // wrap past the top of memory; upper address bits ignored
    wq = '{8'hAB, 8'hCD};
    wr_burst(32'hFF0000 | (MEM_BYTES - 1), 4);
    rd_burst("rd_wrap", MEM_BYTES - 1, 2);
    rd_burst("rd_zero", 0, 1);

    // QPI entry, QPI read and write, then exit
    set_mode(1'b1);
    rd_burst("rd_qpi", 32'h10, 4);
    wq = '{8'h5A, 8'hC3, 8'h0F};
    wr_burst(32'h200, 6);
    rd_burst("rd_qpi_wr", 32'h200, 3);
    set_mode(1'b0);

    // unsupported opcode
    ce_n = 1'b0;
    send_cmd(8'h9F);
    chk("err_pulse", cmd_err, 1);
    chk("err_oe", dio_oe, 0);
    cyc(4'hA);
    chk("err_clr", cmd_err, 0);
    for (int i = 0; i < 4; i++) begin
      chk("ignore_oe", dio_oe, 0);
      cyc(4'h5);
    end
    stop();
    rd_burst("rd_after_err", 32'h10, 2);

    // partial write: 3 of 4 nibbles, second byte must survive
    wq = '{8'h9A, 8'hBC};
    wr_burst(32'h10, 3);
    rd_burst("rd_partial", 32'h10, 2);

    // reset mid-write: no byte may be committed
    wq = '{8'h55};
    wr_burst(32'h20, 2);
    ce_n = 1'b0;
    send_cmd(8'h38);
    send_addr(32'h20);
    cyc(4'hE);
    reset = 1'b1;
    cyc(4'h7);
    reset = 1'b0;
    ce_n  = 1'b1;
    @(negedge sck);
    rd_burst("rd_rst_wr", 32'h20, 1);

    // reset mid-read: outputs drop at once, QPI cleared, memory intact
    set_mode(1'b1);
    ce_n = 1'b0;
    send_cmd(8'hEB);
    send_addr(32'h10);
    repeat (RD_DUMMY) cyc(4'h0);
    cyc(4'h0);
    chk("pre_rst_oe", dio_oe, 4'hF);
    reset = 1'b1;
    #1;
    chk("rst_rd_oe", dio_oe, 0);
    chk("rst_rd_do", dio_o, 0);
    chk("rst_rd_qpi", qpi_mode, 0);
    m_qpi = 1'b0;
    ce_n  = 1'b1;
    @(negedge sck);
    reset = 1'b0;
    @(negedge sck);
    rd_burst("rd_post_rst", 32'h10, 4);

    // random bursts in randomly chosen mode
    for (int it = 0; it < 8; it++) begin
      if ($urandom_range(0, 1) == 1) set_mode(!m_qpi);
      a = int'($urandom_range(0, (1 << ADDR_W) - 1));
      n = int'($urandom_range(1, 5));
      wq.delete();
      for (int k = 0; k < n; k++) wq.push_back(8'($urandom));
      wr_burst(a, 2*n);
      rd_burst("rd_rand", a, n);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
